mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 13, byte-address width on all ports.
REQ-002 Parameter STREAK_MAX, default 4, consecutive load/store grants allowed while a fetch waits (used only with ARB_FAIRNESS_EN).
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 if_req  in  1; if_addr  in  ADDR_W: fetch request and byte address.
REQ-006 if_gnt  out  1; if_valid  out  1; if_err  out  1; if_rdata  out  32: fetch grant, response strobe, misalignment flag, word data.
REQ-007 ls_req  in  1; ls_we  in  1; ls_size  in  3; ls_addr  in  ADDR_W; ls_wdata  in  32: load/store request, size code {lsbit1,lsbit2,lsbit3}.
REQ-008 ls_gnt  out  1; ls_valid  out  1; ls_err  out  1; ls_rdata  out  32: load/store grant, response strobe, error flag, load data.
REQ-009 mem_read  out  1; mem_write  out  1; mem_size  out  3; mem_addr  out  ADDR_W; mem_wdata  out  32; mem_rdata  in  32: shared data-memory port.

Function
REQ-010 FSM states IDLE, ACCESS, RESP; ARB = arbitration point = IDLE or RESP.
REQ-011 In ARB with any req: gnt pulses combinationally for the winner in that cycle, winner's request registered, next state ACCESS; no req: next state IDLE.
REQ-012 Priority: load/store beats fetch when both requested in the same ARB cycle.
REQ-013 Requester may drop req after gnt; an ungranted req is held by the requester until gnt.
REQ-014 ACCESS: drive registered mem_addr, mem_size, mem_wdata for exactly one cycle; mem_read=1 for loads/fetches, mem_write=1 for stores; next state RESP.
REQ-015 RESP: latch mem_rdata into winner's rdata, pulse winner's valid for one cycle; rdata holds until the next response for that requester.
REQ-016 Latency: req at cycle N -> gnt N, mem strobe N+1, valid N+2; back-to-back accesses every 2 cycles.
REQ-017 Fetch size is always 000 (word); if_addr[1:0]!=0 sets if_err with if_valid, if_rdata=0, no mem strobe in ACCESS.
REQ-018 Load/store error: word with addr[1:0]!=0, half (010/100) with addr[0]!=0, size codes 101-111, or store with size 011/100.
REQ-019 Erroneous load/store: gnt still pulses, mem_read/mem_write stay 0 in ACCESS, RESP pulses ls_valid with ls_err=1 and ls_rdata=0.
REQ-020 Stores: ls_valid pulses in RESP as write-acknowledge; ls_rdata unchanged.
REQ-021 mem_read and mem_write never asserted together; both 0 outside ACCESS.
REQ-022 err flags valid only while the matching valid is high; 0 otherwise.

Reset
REQ-023 rst=1 at a rising edge: state IDLE, all gnt/valid/err/mem strobes 0, rdata 0, mem_addr/mem_wdata/mem_size 0, streak counter 0.
REQ-024 rst during ACCESS or RESP drops the in-flight access: no valid pulse issued for it.
REQ-025 While rst=1, gnt outputs forced 0 regardless of req.

Configuration
REQ-026 Macro ARB_FAIRNESS_EN defined: counter counts consecutive load/store grants while if_req=1, clears on any fetch grant or when if_req=0; at STREAK_MAX the next ARB cycle grants fetch even if ls_req=1.
REQ-027 ARB_FAIRNESS_EN undefined: strict load/store priority, no counter, fetch may starve indefinitely.

Verification
REQ-028 if_req, if_addr=0x010, mem_rdata=0x00500093 -> if_gnt cycle 0, mem_read/mem_addr=0x010 cycle 1, if_valid with if_rdata=0x00500093 cycle 2.
REQ-029 if_req and ls_req (load, size 000, addr 0x004) same cycle -> ls_gnt first, if_gnt at cycle 2 RESP, if_valid cycle 4.
REQ-030 Store size 010, addr 0x003 -> ls_gnt, no mem_write, ls_valid with ls_err=1 two cycles later.
REQ-031 With ARB_FAIRNESS_EN, STREAK_MAX=4, both reqs held high -> grant order LS,LS,LS,LS,IF,LS...; without macro -> LS only.
REQ-032 rst asserted in ACCESS of a load -> no ls_valid, all outputs 0 next cycle, fresh request after rst served with normal latency.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch, load/store) onto one single-ported data memory.
// Optional fetch anti-starvation streak limit enabled by defining ARB_FAIRNESS_EN.
module mem_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic              if_err,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [2:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_gnt,
  output logic              ls_valid,
  output logic              ls_err,
  output logic [31:0]       ls_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]        state, state_nxt;
  logic              sel_ls, we_q, err_q;
  logic [2:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, if_rdata_q, ls_rdata_q;
  logic              arb, pick_ls, ls_bad, fetch_force, access, resp;

  `ifdef ARB_FAIRNESS_EN
  localparam int CW = $clog2(STREAK_MAX + 1);
  logic [CW-1:0] streak;

  // Streak only matters while a fetch is actually waiting.
  always_ff @(posedge clk) begin
    if (rst)
      streak <= '0;
    else if (!if_req || if_gnt)
      streak <= '0;
    else if (ls_gnt && streak != CW'(STREAK_MAX))
      streak <= streak + 1'b1;
  end

  assign fetch_force = (streak == CW'(STREAK_MAX));
  `else
  assign fetch_force = 1'b0;
  `endif

  // Size codes: 000 word, 001/011 byte, 010/100 half; 011/100 are load-only.
  always_comb begin
    ls_bad = 1'b1;
    case (ls_size)
      3'b000:  ls_bad = (ls_addr[1:0] != 2'b00);
      3'b001:  ls_bad = 1'b0;
      3'b010:  ls_bad = ls_addr[0];
      3'b011:  ls_bad = ls_we;
      3'b100:  ls_bad = ls_we | ls_addr[0];
      default: ls_bad = 1'b1;
    endcase
  end

  assign arb     = (state == S_IDLE || state == S_RESP) && !rst;
  assign pick_ls = ls_req && !(fetch_force && if_req);
  assign ls_gnt  = arb && pick_ls;
  assign if_gnt  = arb && if_req && !pick_ls;

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE, S_RESP: state_nxt = (if_req || ls_req) ? S_ACCESS : S_IDLE;
      S_ACCESS:       state_nxt = S_RESP;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sel_ls     <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (if_gnt || ls_gnt) begin
        sel_ls  <= ls_gnt;
        we_q    <= ls_gnt & ls_we;
        size_q  <= ls_gnt ? ls_size : 3'b000;
        addr_q  <= ls_gnt ? ls_addr : if_addr;
        wdata_q <= ls_gnt ? ls_wdata : 32'd0;
        err_q   <= ls_gnt ? ls_bad : (if_addr[1:0] != 2'b00);
      end
      if (state == S_RESP) begin
        if (!sel_ls)
          if_rdata_q <= err_q ? 32'd0 : mem_rdata;
        else if (err_q)
          ls_rdata_q <= 32'd0;
        else if (!we_q)
          ls_rdata_q <= mem_rdata;
      end
    end
  end

  assign access    = (state == S_ACCESS);
  assign mem_read  = access && !err_q && !we_q;
  assign mem_write = access && !err_q && we_q;
  assign mem_addr  = access ? addr_q  : '0;
  assign mem_size  = access ? size_q  : 3'b000;
  assign mem_wdata = access ? wdata_q : 32'd0;

  // Read data is returned in the response cycle and held afterwards.
  assign resp     = (state == S_RESP) && !rst;
  assign if_valid = resp && !sel_ls;
  assign if_err   = if_valid && err_q;
  assign if_rdata = if_valid ? (err_q ? 32'd0 : mem_rdata) : if_rdata_q;
  assign ls_valid = resp && sel_ls;
  assign ls_err   = ls_valid && err_q;
  assign ls_rdata = ls_valid ? (err_q ? 32'd0 : (we_q ? ls_rdata_q : mem_rdata)) : ls_rdata_q;

endmodule
